// File: rtl/alu_instr_enc.sv
// -----------------------------------------------------------------------------
// alu_instr_enc
//   Encoder side of the ALU control decoder. It accepts ALU operation requests
//   (ALUControl code plus register fields and an optional immediate) over a
//   valid/ready handshake. For each accepted request it builds the matching
//   RV32I R-type or I-type instruction word and writes that word into
//   instruction memory at an address that advances by one after each write.
//   The self-test program loader uses it to build ALU test programs in place.
//
// Parameters
//   AW        instruction memory word-address width
//   CW        emitted-instruction counter width
//   BASE_ADDR word address of the first write after reset/restart
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   restart           pulse: back to IDLE, address = BASE_ADDR, count = 0
//   req_valid/ready   request handshake
//   req_aluctl        000 add, 001 sub, 010 and, 011 or, 101 slt
//   req_imm_mode      1 = I-type (req_imm), 0 = R-type (req_rs2)
//   req_rd/rs1/rs2    register fields, encoded verbatim (x0 allowed)
//   req_imm           12-bit immediate (I-type only)
//   req_last          marks the final instruction of the program
//   imem_we/addr/wdata  memory write; held stable until imem_ack
//   imem_ack          memory accepted the write this cycle
//   err_illegal       one-cycle pulse after a rejected request
//   instr_count       instructions written (saturating)
//   done              program complete; held until restart/reset
//
// Build option
//   ALU_ENC_NOP_PAD_EN  when defined, a NOP (addi x0,x0,0) is written after
//                       the last instruction, before entering DONE.
// -----------------------------------------------------------------------------
module alu_instr_enc #(
    parameter int              AW        = 8,
    parameter int              CW        = 8,
    parameter logic [AW-1:0]   BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_aluctl,
    input  logic          req_imm_mode,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [11:0]   req_imm,
    input  logic          req_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    input  logic          imem_ack,
    output logic          err_illegal,
    output logic [CW-1:0] instr_count,
    output logic          done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
`ifdef ALU_ENC_NOP_PAD_EN
    localparam logic [1:0] PAD   = 2'd2;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;

    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_q, last_d;
    logic          err_q, err_d;

    logic          legal;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   enc_word;
    logic [CW-1:0] count_inc;

    // ------------------------------------------------------------------
    // Request decode / instruction encode
    // ------------------------------------------------------------------
    // There is no subi in RV32I, so sub is legal only in register form.
    always_comb begin
        legal = 1'b1;
        if (req_aluctl == 3'b100 || req_aluctl == 3'b110 || req_aluctl == 3'b111)
            legal = 1'b0;
        if (req_aluctl == 3'b001 && req_imm_mode)
            legal = 1'b0;
    end

    always_comb begin
        funct3 = 3'b000;
        case (req_aluctl)
            3'b000, 3'b001: funct3 = 3'b000;
            3'b010:         funct3 = 3'b111;
            3'b011:         funct3 = 3'b110;
            3'b101:         funct3 = 3'b010;
            default:        funct3 = 3'b000;
        endcase
    end

    assign funct7   = (req_aluctl == 3'b001) ? 7'b0100000 : 7'b0000000;
    assign enc_word = req_imm_mode
                    ? {req_imm, req_rs1, funct3, req_rd, OPC_I}
                    : {funct7, req_rs2, req_rs1, funct3, req_rd, OPC_R};

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = 1'b0;

        if (restart) begin
            // Abandons any pending write, even if it is acked this cycle.
            state_d = IDLE;
            addr_d  = BASE_ADDR;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        if (legal) begin
                            wdata_d = enc_word;
                            last_d  = req_last;
                            state_d = WRITE;
                        end else begin
                            err_d   = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ack) begin
                        addr_d  = addr_q + ADDR_ONE;
                        count_d = count_inc;
                        if (last_q) begin
`ifdef ALU_ENC_NOP_PAD_EN
                            state_d = PAD;
                            wdata_d = NOP_WORD;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
`ifdef ALU_ENC_NOP_PAD_EN
                PAD: begin
                    if (imem_ack) begin
                        addr_d  = addr_q + ADDR_ONE;
                        count_d = count_inc;
                        state_d = DONE;
                    end
                end
`endif
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Ready is masked by reset/restart so a request offered in those
    // cycles is never counted as transferred.
    assign req_ready = (state_q == IDLE) && !reset && !restart;
`ifdef ALU_ENC_NOP_PAD_EN
    assign imem_we   = (state_q == WRITE) || (state_q == PAD);
`else
    assign imem_we   = (state_q == WRITE);
`endif
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign err_illegal = err_q;
    assign instr_count = count_q;
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_alu_instr_enc.sv
module tb_alu_instr_enc;

    logic        clk;
    logic        reset, restart;
    logic        req_valid, w_valid;
    logic        req_ready, w_ready;
    logic [2:0]  req_aluctl;
    logic        req_imm_mode;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [11:0] req_imm;
    logic        req_last;
    logic        imem_we, w_we;
    logic [7:0]  imem_addr, w_addr;
    logic [31:0] imem_wdata, w_wdata;
    logic        imem_ack, w_ack;
    logic        err_illegal, w_err;
    logic [7:0]  instr_count, w_count;
    logic        done, w_done;

    int n_tests = 0;
    int n_fail  = 0;
    bit mdl_en  = 0;

    alu_instr_enc #(.AW(8), .CW(8), .BASE_ADDR(8'd0)) u_dut (
        .clk(clk), .reset(reset), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluctl(req_aluctl), .req_imm_mode(req_imm_mode),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .err_illegal(err_illegal),
        .instr_count(instr_count), .done(done)
    );

    // Second instance starting at the top of the address space.
    alu_instr_enc #(.AW(8), .CW(8), .BASE_ADDR(8'd255)) u_wrap (
        .clk(clk), .reset(reset), .restart(1'b0),
        .req_valid(w_valid), .req_ready(w_ready),
        .req_aluctl(req_aluctl), .req_imm_mode(req_imm_mode),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .imem_we(w_we), .imem_addr(w_addr), .imem_wdata(w_wdata),
        .imem_ack(w_ack), .err_illegal(w_err),
        .instr_count(w_count), .done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: field arithmetic straight from the RV32I layout.
    // ------------------------------------------------------------------
    function automatic bit m_legal(input logic [2:0] ctl, input logic im);
        if (ctl == 3'd4 || ctl == 3'd6 || ctl == 3'd7) return 0;
        if (ctl == 3'd1 && im) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_enc(input logic [2:0] ctl, input logic im,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [11:0] imm);
        longint f3, f7, w;
        f7 = 0;
        case (ctl)
            3'd1:    begin f3 = 0; f7 = 32; end
            3'd2:    f3 = 7;
            3'd3:    f3 = 6;
            3'd5:    f3 = 2;
            default: f3 = 0;
        endcase
        if (im) w = longint'(imm) * (2**20) + longint'(rs1) * (2**15) + f3 * 4096
                    + longint'(rd) * 128 + 19;
        else    w = f7 * (2**25) + longint'(rs2) * (2**20) + longint'(rs1) * (2**15)
                    + f3 * 4096 + longint'(rd) * 128 + 51;
        return w[31:0];
    endfunction

    logic [31:0] q[$];
    logic [7:0]  m_addr, m_count;
    bit          m_done, m_err, m_last;

    // Compare process: outputs are checked every cycle, then the model
    // applies what the coming rising edge will do.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            m_addr = 8'd0; m_count = 8'd0;
            m_done = 0; m_err = 0; m_last = 0;
        end else if (mdl_en) begin
            chk("m_ready", req_ready, !m_done && q.size() == 0 && !restart);
            chk("m_we",    imem_we,   q.size() != 0);
            chk("m_done",  done,      m_done);
            chk("m_err",   err_illegal, m_err);
            chk("m_count", instr_count, m_count);
            chk("m_addr",  imem_addr, m_addr);
            if (q.size() != 0) chk("m_wdata", imem_wdata, q[0]);
            m_err = 0;
            if (restart) begin
                q.delete();
                m_addr = 8'd0; m_count = 8'd0; m_done = 0;
            end else if (q.size() != 0) begin
                if (imem_ack) begin
                    void'(q.pop_front());
                    m_addr++;
                    if (m_count != 8'hFF) m_count++;
                    if (q.size() == 0 && m_last) m_done = 1;
                end
            end else if (!m_done && req_valid) begin
                if (m_legal(req_aluctl, req_imm_mode)) begin
                    q.push_back(m_enc(req_aluctl, req_imm_mode, req_rd, req_rs1, req_rs2, req_imm));
`ifdef ALU_ENC_NOP_PAD_EN
                    if (req_last) q.push_back(32'h0000_0013);
`endif
                    m_last = req_last;
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drive at posedge+1)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input logic [2:0] ctl, input logic im, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] imm, input logic last);
        req_aluctl = ctl; req_imm_mode = im; req_rd = rd; req_rs1 = rs1;
        req_rs2 = rs2; req_imm = imm; req_last = last;
    endtask

    task automatic send(input logic [2:0] ctl, input logic im, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [11:0] imm, input logic last);
        bit ok = 0;
        set_req(ctl, im, rd, rs1, rs2, imm, last);
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk("send_accepted", ok, 1'b1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1; step(); restart = 1'b0;
    endtask

    initial begin
        int wecnt;
        reset = 1'b1; restart = 1'b0; req_valid = 1'b0; w_valid = 1'b0;
        imem_ack = 1'b1; w_ack = 1'b1;
        set_req(3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);

        // Reset state
        step();
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_we",    imem_we, 1'b0);
        chk("rst_addr",  imem_addr, 8'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_err",   err_illegal, 1'b0);
        chk("rst_count", instr_count, 8'd0);
        chk("rst_done",  done, 1'b0);
        chk("rst_waddr", w_addr, 8'd255);
        step();
        reset = 1'b0;
        mdl_en = 1;

        // add x3,x1,x2 with ack tied high
        send(3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        @(negedge clk);
        chk("add_we",    imem_we, 1'b1);
        chk("add_addr",  imem_addr, 8'd0);
        chk("add_wdata", imem_wdata, 32'h002081B3);
        step();
        @(negedge clk);
        chk("add_we_drop", imem_we, 1'b0);
        chk("add_count",   instr_count, 8'd1);
        step();

        // sub x5,x6,x7 then ori x4,x4,0xFF (last)
        pulse_restart();
        send(3'd1, 1'b0, 5'd5, 5'd6, 5'd7, 12'd0, 1'b0);
        @(negedge clk);
        chk("sub_addr",  imem_addr, 8'd0);
        chk("sub_wdata", imem_wdata, 32'h407302B3);
        step();
        send(3'd3, 1'b1, 5'd4, 5'd4, 5'd0, 12'h0FF, 1'b1);
        @(negedge clk);
        chk("ori_addr",  imem_addr, 8'd1);
        chk("ori_wdata", imem_wdata, 32'h0FF26213);
        step();
`ifdef ALU_ENC_NOP_PAD_EN
        @(negedge clk);
        chk("pad_addr",  imem_addr, 8'd2);
        chk("pad_wdata", imem_wdata, 32'h00000013);
        step();
        @(negedge clk);
        chk("prog_count", instr_count, 8'd3);
`else
        @(negedge clk);
        chk("prog_count", instr_count, 8'd2);
`endif
        chk("prog_done",  done, 1'b1);
        chk("prog_ready", req_ready, 1'b0);
        step();
        step();
        @(negedge clk);
        chk("done_held", done, 1'b1);
        step();

        // slti x1,x2,-1 with ack delayed three cycles
        pulse_restart();
        imem_ack = 1'b0;
        send(3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 12'hFFF, 1'b0);
        wecnt = 0;
        @(negedge clk);
        if (imem_we) wecnt++;
        chk("slti_wdata", imem_wdata, 32'hFFF12093);
        step();
        @(negedge clk); if (imem_we) wecnt++;
        step();
        @(negedge clk); if (imem_we) wecnt++;
        step();
        imem_ack = 1'b1;
        @(negedge clk); if (imem_we) wecnt++;
        step();
        @(negedge clk);
        chk("slti_we_cycles", wecnt, 4);
        chk("slti_we_drop",   imem_we, 1'b0);
        chk("slti_count",     instr_count, 8'd1);
        step();

        // Illegal requests
        send(3'd6, 1'b0, 5'd1, 5'd1, 5'd1, 12'd0, 1'b0);
        @(negedge clk);
        chk("ill110_err", err_illegal, 1'b1);
        chk("ill110_we",  imem_we, 1'b0);
        step();
        @(negedge clk);
        chk("ill110_pulse", err_illegal, 1'b0);
        step();
        send(3'd1, 1'b1, 5'd1, 5'd1, 5'd0, 12'd5, 1'b0);
        @(negedge clk);
        chk("subi_err", err_illegal, 1'b1);
        step();
        @(negedge clk);
        chk("subi_pulse", err_illegal, 1'b0);
        chk("ill_addr",   imem_addr, 8'd1);
        chk("ill_count",  instr_count, 8'd1);
        step();

        // Restart while a write is pending
        imem_ack = 1'b0;
        send(3'd2, 1'b0, 5'd9, 5'd10, 5'd11, 12'd0, 1'b0);
        @(negedge clk);
        chk("rw_we", imem_we, 1'b1);
        step();
        imem_ack = 1'b1;
        pulse_restart();
        @(negedge clk);
        chk("rw_we_drop", imem_we, 1'b0);
        chk("rw_addr",    imem_addr, 8'd0);
        chk("rw_count",   instr_count, 8'd0);
        step();

`ifdef ALU_ENC_NOP_PAD_EN
        // Single add with last=1 followed by NOP padding
        send(3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b1);
        @(negedge clk);
        chk("padrun_wdata0", imem_wdata, 32'h002081B3);
        step();
        @(negedge clk);
        chk("padrun_addr1",  imem_addr, 8'd1);
        chk("padrun_wdata1", imem_wdata, 32'h00000013);
        step();
        @(negedge clk);
        chk("padrun_count", instr_count, 8'd2);
        chk("padrun_done",  done, 1'b1);
        step();
`endif

        // Address wrap on the BASE_ADDR=255 instance
        set_req(3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        w_valid = 1'b1;
        @(negedge clk);
        chk("wrap_ready0", w_ready, 1'b1);
        step();
        w_valid = 1'b0;
        @(negedge clk);
        chk("wrap_we0",   w_we, 1'b1);
        chk("wrap_addr0", w_addr, 8'd255);
        step();
        w_valid = 1'b1;
        @(negedge clk);
        chk("wrap_ready1", w_ready, 1'b1);
        step();
        w_valid = 1'b0;
        @(negedge clk);
        chk("wrap_we1",   w_we, 1'b1);
        chk("wrap_addr1", w_addr, 8'd0);
        step();
        @(negedge clk);
        chk("wrap_count", w_count, 8'd2);
        chk("wrap_err",   w_err, 1'b0);
        chk("wrap_done",  w_done, 1'b0);
        step();

        mdl_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
